// File: rtl/token_assembler.sv
// token_assembler
//   Buffers keypad events in a small FIFO and turns them into a token stream
//   for a calculator. Decimal digits are accumulated into an operand. An
//   operator key emits the pending operand (if any) followed by the operator
//   token. The clear key emits only the clear operator token. Each token is
//   handed over with a one-cycle strobe. The next token is not issued until
//   the calculator reports calc_ready again.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   key_valid  one-cycle key event qualifier
//   key_code   0-9 digit, A + , B - , C * , D / , E = , F clear
//   calc_ready calculator idle / accepting tokens
//   token      operand (bit31=0) or operator 32'h8000000A..F, held between strobes
//   strobe     one-cycle token-valid pulse
//   entry_val  current digit accumulator (display)
//   busy       FSM not idle or FIFO not empty
//   key_drop   sticky: a key was lost to a full FIFO
module token_assembler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        calc_ready,
  output logic [31:0] token,
  output logic        strobe,
  output logic [31:0] entry_val,
  output logic        busy,
  output logic        key_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    EMIT_NUM,
    WAIT_NUM,
    EMIT_OP,
    WAIT_OP
  } state_t;

  state_t             state_q,    state_d;
  logic [31:0]        acc_q,      acc_d;
  logic               pending_q,  pending_d;
  logic [3:0]         op_q,       op_d;
  logic [31:0]        token_q,    token_d;
  logic               strobe_q,   strobe_d;
  logic               guard_q,    guard_d;
  logic               key_drop_q, key_drop_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [3:0]         fifo_q [FIFO_DEPTH];

  logic        full;
  logic        pop;
  logic        push;
  logic [3:0]  head;
  logic [35:0] acc_next;

  // ---------------- key FIFO control ----------------
  always_comb begin
    head = fifo_q[rd_ptr_q];
    full = (cnt_q == CNT_W'(FIFO_DEPTH));
    pop  = (state_q == IDLE) && (cnt_q != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    push = key_valid && (!full || pop);

    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d      = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    key_drop_d = key_drop_q | (key_valid && !push);
  end

  // ---------------- token FSM ----------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    pending_d = pending_q;
    op_d      = op_q;
    token_d   = token_q;
    strobe_d  = 1'b0;
    guard_d   = 1'b0;
    // Widened so the overflow test sees the true value of acc*10+d.
    acc_next  = 36'(acc_q) * 36'd10 + 36'(head);

    // token/strobe are registered on entry to an EMIT state, so strobe is
    // high exactly while the FSM sits in EMIT_NUM / EMIT_OP.
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (head <= 4'd9) begin
            if (acc_next <= 36'h0_7FFF_FFFF) begin
              acc_d     = acc_next[31:0];
              pending_d = 1'b1;
            end
          end else if (head == 4'hF) begin
            acc_d     = '0;
            pending_d = 1'b0;
            op_d      = head;
            state_d   = EMIT_OP;
            token_d   = {28'h8000000, head};
            strobe_d  = 1'b1;
          end else if (pending_q) begin
            op_d      = head;
            state_d   = EMIT_NUM;
            token_d   = acc_q;
            strobe_d  = 1'b1;
          end else begin
            op_d      = head;
            state_d   = EMIT_OP;
            token_d   = {28'h8000000, head};
            strobe_d  = 1'b1;
          end
        end
      end
      EMIT_NUM: begin
        state_d = WAIT_NUM;
        guard_d = 1'b1;
      end
      WAIT_NUM: begin
        // guard_q marks the first WAIT cycle, where calc_ready may still
        // reflect the calculator's state from before it saw the strobe.
        if (!guard_q && calc_ready) begin
          state_d  = EMIT_OP;
          token_d  = {28'h8000000, op_q};
          strobe_d = 1'b1;
        end
      end
      EMIT_OP: begin
        state_d = WAIT_OP;
        guard_d = 1'b1;
      end
      WAIT_OP: begin
        if (!guard_q && calc_ready) begin
          state_d   = IDLE;
          acc_d     = '0;
          pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      pending_q  <= 1'b0;
      op_q       <= '0;
      token_q    <= '0;
      strobe_q   <= 1'b0;
      guard_q    <= 1'b0;
      key_drop_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pending_q  <= pending_d;
      op_q       <= op_d;
      token_q    <= token_d;
      strobe_q   <= strobe_d;
      guard_q    <= guard_d;
      key_drop_q <= key_drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count
  // define which entries are valid, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= key_code;
  end

  assign token     = token_q;
  assign strobe    = strobe_q;
  assign entry_val = acc_q;
  assign busy      = (state_q != IDLE) || (cnt_q != '0);
  assign key_drop  = key_drop_q;

endmodule

// File: tb/tb_token_assembler.sv
// tb_token_assembler
//   Self-checking bench for token_assembler: a table of key sequences with
//   their expected token streams, hand-written multi-cycle sequences (stall,
//   full FIFO, drop, reset mid-handshake) and a randomized run checked
//   against a key-level reference model.
module tb_token_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        calc_ready = 1'b0;
  logic [31:0] token;
  logic        strobe;
  logic [31:0] entry_val;
  logic        busy;
  logic        key_drop;

  always #5 clk = ~clk;

  token_assembler #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .calc_ready (calc_ready),
    .token      (token),
    .strobe     (strobe),
    .entry_val  (entry_val),
    .busy       (busy),
    .key_drop   (key_drop)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] cap_q [$];
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- strobe/token monitor ----------------
  logic        rst_prev    = 1'b1;
  logic        prev_strobe = 1'b0;
  logic [31:0] last_tok    = '0;

  always @(negedge clk) begin
    if (rst_prev) begin
      last_tok = '0;
      check("rst_strobe", strobe, 0);
      check("rst_token", token, 0);
    end else if (strobe) begin
      check("strobe_single_cycle", prev_strobe, 0);
      cap_q.push_back(token);
      last_tok = token;
    end else begin
      check("token_hold", token, last_tok);
    end
    prev_strobe = strobe;
    rst_prev    = rst;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    key_valid = 1'b1;   // must be ignored while rst is high
    key_code  = 4'h5;
    tick();
    tick();
    rst       = 1'b0;
    key_valid = 1'b0;
    tick();
    check("reset_busy", busy, 0);
    check("reset_entry", entry_val, 0);
    check("reset_key_drop", key_drop, 0);
    check("reset_token", token, 0);
    check("reset_strobe", strobe, 0);
  endtask

  task automatic push_key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, input bit rand_ready);
    int n = 0;
    while (busy && n < budget) begin
      if (rand_ready) calc_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_tokens(input string name, input int cnt, input int budget);
    int n = 0;
    while (cap_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    check({name, "_token_count"}, cap_q.size(), cnt);
  endtask

  task automatic compare_tokens(input string name);
    logic [31:0] act;
    check({name, "_num_tokens"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF;
      check($sformatf("%s_tok%0d", name, i), act, exp_q[i]);
    end
  endtask

  // ---------------- reference model (key-level semantics) ----------------
  longint m_acc;
  bit     m_pend;

  task automatic model_key(input logic [3:0] k);
    if (k <= 4'd9) begin
      if (m_acc * 10 + longint'(k) <= 64'h7FFF_FFFF) begin
        m_acc  = m_acc * 10 + longint'(k);
        m_pend = 1'b1;
      end
    end else if (k == 4'hF) begin
      exp_q.push_back(32'h8000_000F);
      m_acc  = 0;
      m_pend = 1'b0;
    end else begin
      if (m_pend) exp_q.push_back(32'(m_acc));
      exp_q.push_back({28'h8000000, k});
      m_acc  = 0;
      m_pend = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  // keys: first key in the top nibble; toks: first token in the top word.
  typedef struct packed {
    int           n_keys;
    logic [63:0]  keys;
    int           n_tok;
    logic [127:0] toks;
    logic [31:0]  exp_entry;
  } vec_t;

  localparam int N_VEC = 9;
  vec_t vecs [N_VEC];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : main
    vec_t        cur;
    logic [3:0]  k;

    vecs[0] = '{n_keys: 5,  keys: 64'h18A9_E000_0000_0000, n_tok: 4,
                toks: {32'd18, 32'h8000_000A, 32'd9, 32'h8000_000E}, exp_entry: 32'd0};
    vecs[1] = '{n_keys: 2,  keys: 64'hFA00_0000_0000_0000, n_tok: 2,
                toks: {32'h8000_000F, 32'h8000_000A, 64'd0}, exp_entry: 32'd0};
    vecs[2] = '{n_keys: 12, keys: 64'h2147_4836_479E_0000, n_tok: 2,
                toks: {32'd2147483647, 32'h8000_000E, 64'd0}, exp_entry: 32'd0};
    vecs[3] = '{n_keys: 3,  keys: 64'h1230_0000_0000_0000, n_tok: 0,
                toks: 128'd0, exp_entry: 32'd123};
    vecs[4] = '{n_keys: 11, keys: 64'h2147_4836_4790_0000, n_tok: 0,
                toks: 128'd0, exp_entry: 32'd2147483647};
    vecs[5] = '{n_keys: 3,  keys: 64'h05B0_0000_0000_0000, n_tok: 2,
                toks: {32'd5, 32'h8000_000B, 64'd0}, exp_entry: 32'd0};
    vecs[6] = '{n_keys: 2,  keys: 64'h0C00_0000_0000_0000, n_tok: 2,
                toks: {32'd0, 32'h8000_000C, 64'd0}, exp_entry: 32'd0};
    vecs[7] = '{n_keys: 3,  keys: 64'h7F30_0000_0000_0000, n_tok: 1,
                toks: {32'h8000_000F, 96'd0}, exp_entry: 32'd3};
    vecs[8] = '{n_keys: 2,  keys: 64'h4D00_0000_0000_0000, n_tok: 2,
                toks: {32'd4, 32'h8000_000D, 64'd0}, exp_entry: 32'd0};

    reset_dut();

    // ---- table-driven sequences, calc_ready held high ----
    for (int v = 0; v < N_VEC; v++) begin
      cur = vecs[v];
      reset_dut();
      calc_ready = 1'b1;
      cap_q.delete();
      exp_q.delete();
      for (int i = 0; i < cur.n_tok; i++) exp_q.push_back(cur.toks[127-32*i -: 32]);
      for (int i = 0; i < cur.n_keys; i++) push_key(cur.keys[63-4*i -: 4]);
      wait_idle($sformatf("vec%0d", v), 300, 1'b0);
      compare_tokens($sformatf("vec%0d", v));
      check($sformatf("vec%0d_entry", v), entry_val, cur.exp_entry);
      check($sformatf("vec%0d_key_drop", v), key_drop, 0);
    end

    // ---- stall: calc_ready low for 10 cycles after the operand strobe ----
    reset_dut();
    calc_ready = 1'b0;
    cap_q.delete();
    exp_q.delete();
    push_key(4'h5);
    push_key(4'hA);
    wait_tokens("stall_first", 1, 50);
    push_key(4'h6);
    push_key(4'hB);
    push_key(4'h2);
    for (int i = 0; i < 7; i++) tick();
    check("stall_no_strobe", cap_q.size(), 1);
    check("stall_key_drop", key_drop, 0);
    check("stall_busy", busy, 1);
    calc_ready = 1'b1;
    exp_q = '{32'd5, 32'h8000_000A, 32'd6, 32'h8000_000B};
    wait_idle("stall", 300, 1'b0);
    compare_tokens("stall");
    check("stall_entry", entry_val, 32'd2);

    // ---- full FIFO with simultaneous pop and push: no drop ----
    reset_dut();
    calc_ready = 1'b0;
    cap_q.delete();
    push_key(4'hA);
    push_key(4'h1);
    push_key(4'h2);
    push_key(4'h3);
    push_key(4'h4);
    check("full_key_drop_before", key_drop, 0);
    calc_ready = 1'b1;   // WAIT_OP exits at the next edge
    tick();
    push_key(4'h5);      // first IDLE cycle: FIFO full and popping
    wait_idle("full_pop_push", 100, 1'b0);
    check("full_pop_push_key_drop", key_drop, 0);
    check("full_pop_push_entry", entry_val, 32'd12345);
    exp_q = '{32'h8000_000A};
    compare_tokens("full_pop_push");

    // ---- overflow of a stalled FIFO: sticky key_drop, cleared by reset ----
    calc_ready = 1'b0;
    push_key(4'hB);
    wait_tokens("drop_operand", 2, 50);
    check("drop_operand_value", cap_q[1], 32'd12345);
    for (int i = 0; i < 5; i++) push_key(4'h7);
    check("drop_set", key_drop, 1);
    tick();
    tick();
    tick();
    check("drop_sticky", key_drop, 1);
    check("drop_busy", busy, 1);
    reset_dut();

    // ---- reset during WAIT_OP, then resume ----
    calc_ready = 1'b0;
    cap_q.delete();
    push_key(4'hE);
    wait_tokens("rst_wait_op", 1, 50);
    tick();
    tick();
    reset_dut();
    cap_q.delete();
    calc_ready = 1'b1;
    push_key(4'h3);
    push_key(4'hE);
    wait_idle("after_rst", 100, 1'b0);
    exp_q = '{32'd3, 32'h8000_000E};
    compare_tokens("after_rst");

    // ---- randomized bursts against the reference model ----
    reset_dut();
    cap_q.delete();
    exp_q.delete();
    m_acc  = 0;
    m_pend = 1'b0;
    for (int b = 0; b < 60; b++) begin
      int n_burst = $urandom_range(1, 4);
      for (int i = 0; i < n_burst; i++) begin
        k = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        model_key(k);
        calc_ready = 1'($urandom_range(0, 1));
        push_key(k);
      end
      wait_idle($sformatf("rand_b%0d", b), 500, 1'b1);
      calc_ready = 1'b1;
    end
    compare_tokens("rand");
    check("rand_entry", entry_val, 32'(m_acc));
    check("rand_key_drop", key_drop, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
